// File: rtl/ritc_pkg.sv
// Shared RITC definitions: sample/beat geometry, playback state encoding
// and the helper that assembles one 48-bit beat from its two 24-bit halves.
package ritc_pkg;

    localparam int RITC_SAMPLE_W = 3;
    localparam int RITC_BEAT_W   = 48;
    localparam int RITC_HALF_W   = 24;

    typedef enum logic [1:0] {
        PB_IDLE  = 2'd0,
        PB_ARMED = 2'd1,
        PB_PLAY  = 2'd2
    } pb_state_e;

    // Beat layout: hi half carries samples 8..15, lo half samples 0..7.
    function automatic logic [RITC_BEAT_W-1:0] pack_beat(
        input logic [RITC_HALF_W-1:0] hi,
        input logic [RITC_HALF_W-1:0] lo
    );
        return {hi, lo};
    endfunction

endpackage

// File: rtl/ritc_pattern_playback_if.sv
// User register bus used to load and read back the playback pattern RAM.
interface ritc_pattern_playback_if #(
    parameter int AW = 10
);
    logic          user_sel_i;
    logic          user_wr_i;
    logic          user_rd_i;
    logic [AW-1:0] user_addr_i;
    logic [31:0]   user_dat_i;
    logic [31:0]   user_dat_o;

    modport master (
        output user_sel_i, user_wr_i, user_rd_i, user_addr_i, user_dat_i,
        input  user_dat_o
    );

    modport slave (
        input  user_sel_i, user_wr_i, user_rd_i, user_addr_i, user_dat_i,
        output user_dat_o
    );
endinterface

// File: rtl/ritc_pattern_bank.sv
// One 24-bit half of the pattern store. Port A is the user side (write plus
// enabled registered read, read-first), port B is the free-running playback read.
module ritc_pattern_bank
    import ritc_pkg::*;
#(
    parameter int DEPTH_W = 9,
    parameter int WIDTH   = RITC_HALF_W
) (
    input  logic               sysclk_i,
    input  logic               rst_n_i,
    input  logic               we_a,
    input  logic               re_a,
    input  logic [DEPTH_W-1:0] addr_a,
    input  logic [WIDTH-1:0]   wdat_a,
    output logic [WIDTH-1:0]   rdat_a,
    input  logic [DEPTH_W-1:0] addr_b,
    output logic [WIDTH-1:0]   rdat_b
);

    logic [WIDTH-1:0] mem [2**DEPTH_W];

    // User write port; contents are deliberately left out of reset.
    always_ff @(posedge sysclk_i) begin
        if (we_a) begin
            mem[addr_a] <= wdat_a;
        end
    end

    // User read register: holds between strobes, returns pre-write data on a same-cycle write.
    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdat_a <= '0;
        end else if (re_a) begin
            rdat_a <= mem[addr_a];
        end
    end

    // Playback read register, one cycle behind the address.
    always_ff @(posedge sysclk_i) begin
        rdat_b <= mem[addr_b];
    end

endmodule

// File: rtl/ritc_pattern_playback.sv
// Replays a user-loaded pattern as contiguous 48-bit beats in place of live
// RITC data. Launch waits for the sync_i=0 phase; beat k leaves two cycles
// after the launch cycle plus k, with no bubbles across loop wraps.
module ritc_pattern_playback
    import ritc_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic                   sysclk_i,
    input  logic                   rst_n_i,
    input  logic                   sync_i,
    ritc_pattern_playback_if.slave ubus,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic                   loop_i,
    input  logic [AW-2:0]          length_i,
    output logic [RITC_BEAT_W-1:0] dat_o,
    output logic                   valid_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam logic [1:0] ST_IDLE  = 2'(PB_IDLE);
    localparam logic [1:0] ST_ARMED = 2'(PB_ARMED);
    localparam logic [1:0] ST_PLAY  = 2'(PB_PLAY);

    logic [1:0]             state, state_nxt;
    logic [AW-2:0]          cnt, cnt_nxt;
    logic [AW-2:0]          len_q;
    logic                   loop_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   start_acc;
    logic                   kill;
    logic                   issue_p0;
    logic                   at_end_p0;
    logic                   last_p0;

    logic                   vld_p1;
    logic                   last_p1;
    logic [RITC_HALF_W-1:0] pb_lo_p1, pb_hi_p1;

    logic                   vld_p2;
    logic [RITC_BEAT_W-1:0] dat_p2;

    logic [AW-2:0]          user_idx;
    logic                   user_re;
    logic                   we_lo, we_hi;
    logic                   user_half_p1;
    logic [RITC_HALF_W-1:0] rd_lo, rd_hi;
    logic                   unused_dat_hi;

    // Upper byte of the write word carries no pattern data.
    assign unused_dat_hi = ^ubus.user_dat_i[31:RITC_HALF_W];

    assign start_acc = (state == ST_IDLE) && start_i && !stop_i;
    assign kill      = stop_i && busy_q;
    assign issue_p0  = !stop_i && (((state == ST_ARMED) && !sync_i) || (state == ST_PLAY));
    assign at_end_p0 = (cnt == len_q);
    assign last_p0   = issue_p0 && at_end_p0 && !loop_q;

    // Next-state and beat-counter decode; cnt always names the beat read this cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (start_acc) begin
                    state_nxt = ST_ARMED;
                    cnt_nxt   = '0;
                end
            end
            ST_ARMED, ST_PLAY: begin
                if (stop_i) begin
                    state_nxt = ST_IDLE;
                end else if (issue_p0) begin
                    if (at_end_p0) begin
                        cnt_nxt   = '0;
                        state_nxt = loop_q ? ST_PLAY : ST_IDLE;
                    end else begin
                        cnt_nxt   = cnt + 1'b1;
                        state_nxt = ST_PLAY;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control state, run parameters latched at the accepted start.
    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            len_q  <= '0;
            loop_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            busy_q <= (state_nxt != ST_IDLE);
            if (start_acc) begin
                len_q  <= length_i;
                loop_q <= loop_i;
            end
        end
    end

    // ---- p0 -> p1: both banks read beat cnt ----
    ritc_pattern_bank #(.DEPTH_W(AW-1)) u_bank_lo (
        .sysclk_i (sysclk_i),
        .rst_n_i  (rst_n_i),
        .we_a     (we_lo),
        .re_a     (user_re),
        .addr_a   (user_idx),
        .wdat_a   (ubus.user_dat_i[RITC_HALF_W-1:0]),
        .rdat_a   (rd_lo),
        .addr_b   (cnt),
        .rdat_b   (pb_lo_p1)
    );

    ritc_pattern_bank #(.DEPTH_W(AW-1)) u_bank_hi (
        .sysclk_i (sysclk_i),
        .rst_n_i  (rst_n_i),
        .we_a     (we_hi),
        .re_a     (user_re),
        .addr_a   (user_idx),
        .wdat_a   (ubus.user_dat_i[RITC_HALF_W-1:0]),
        .rdat_a   (rd_hi),
        .addr_b   (cnt),
        .rdat_b   (pb_hi_p1)
    );

    // Valid and end-of-run marker travel alongside the RAM read.
    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            vld_p1  <= issue_p0;
            last_p1 <= last_p0;
        end
    end

    // ---- p1 -> p2: output register, zeroed when idle or aborted ----
    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_p2 <= 1'b0;
            dat_p2 <= '0;
        end else if (kill) begin
            vld_p2 <= 1'b0;
            dat_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1;
            dat_p2 <= vld_p1 ? pack_beat(pb_hi_p1, pb_lo_p1) : '0;
        end
    end

    // One-shot completion flag rises with the last beat and holds until the next start.
    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            done_q <= 1'b0;
        end else if (last_p1 && !kill) begin
            done_q <= 1'b1;
        end else if (start_acc) begin
            done_q <= 1'b0;
        end
    end

    assign dat_o   = dat_p2;
    assign valid_o = vld_p2;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

    // User bus: bit 0 picks the half, upper bits the beat; writes are locked out while busy.
    assign user_idx = ubus.user_addr_i[AW-1:1];
    assign user_re  = ubus.user_sel_i && ubus.user_rd_i;
    assign we_lo    = ubus.user_sel_i && ubus.user_wr_i && !busy_q && !ubus.user_addr_i[0];
    assign we_hi    = ubus.user_sel_i && ubus.user_wr_i && !busy_q &&  ubus.user_addr_i[0];

    // Remember which half the last read addressed so the holding data stays selected.
    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            user_half_p1 <= 1'b0;
        end else if (user_re) begin
            user_half_p1 <= ubus.user_addr_i[0];
        end
    end

    assign ubus.user_dat_o = {{(32-RITC_HALF_W){1'b0}}, (user_half_p1 ? rd_hi : rd_lo)};

endmodule

// File: doc/ritc_pattern_playback.md
Name: ritc_pattern_playback

Overview:
- Transmit-side counterpart to the RITC sample capture path.
- The user bus loads a pattern of 3-bit-sample words into on-chip RAM.
- On start, the block replays the pattern as 48-bit beats (16 samples × 3 bits), aligned to the sysclk sync phase.
- Output feeds the datapath in place of live RITC data, for trigger/correlator test and loopback against the capture buffer.

Parameters:
- AW, 10: pattern word address width. 2^AW 24-bit words, i.e. 2^(AW-1) beats; default 512 beats matches capture depth.

Ports:
- sysclk_i  in  1  sole clock
- rst_n_i  in  1  asynchronous active-low reset
- sync_i  in  1  sysclk phase marker; playback launches only where sync_i=0
- user_sel_i  in  1  user bus select
- user_wr_i  in  1  write strobe (qualified by user_sel_i)
- user_rd_i  in  1  read strobe (qualified by user_sel_i)
- user_addr_i  in  AW  pattern word address; bit0 = beat half (0: [23:0], 1: [47:24]), [AW-1:1] = beat index
- user_dat_i  in  32  write data; [23:0] used
- user_dat_o  out  32  read data {8'h00, word}
- start_i  in  1  one-cycle start pulse
- stop_i  in  1  one-cycle abort pulse
- loop_i  in  1  sampled at start; 1 = repeat forever
- length_i  in  AW-1  sampled at start; beats minus one
- dat_o  out  48  playback beat
- valid_o  out  1  dat_o holds a pattern beat
- busy_o  out  1  state ARMED or PLAY
- done_o  out  1  one-shot playback completed

Behaviour:
- Reset (async, rst_n_i=0): state IDLE; dat_o=0, valid_o=0, busy_o=0, done_o=0, user_dat_o=0. Counters and latched length/loop cleared. RAM contents not reset.
- Storage: two 24-bit banks (lo/hi), 2^(AW-1) deep each, so one full beat is read per cycle.
- User write: user_sel_i&user_wr_i writes user_dat_i[23:0] to bank user_addr_i[0] at index user_addr_i[AW-1:1]. Writes are dropped while busy_o=1.
- User read: user_sel_i&user_rd_i loads user_dat_o with the addressed word on the next cycle (1-cycle latency). Otherwise user_dat_o holds. Reads are allowed at any time. Simultaneous rd+wr to the same address in IDLE returns old data.
- FSM states: IDLE, ARMED, PLAY.
  - IDLE: start_i & !stop_i → ARMED. Latch length_i and loop_i; clear done_o; clear beat counter.
  - ARMED: stop_i → IDLE. Else sync_i=0 → PLAY, issuing the read of beat 0 in that cycle (cycle T).
  - PLAY: reads beat counter+1 each cycle. At counter == latched length: loop=1 → wrap to 0 with no gap; loop=0 → IDLE. stop_i → IDLE.
- Latency: beat k appears on dat_o with valid_o=1 at cycle T+2+k. Beats are contiguous with no bubbles, including across loop wrap.
- When valid_o=0, dat_o=0.
- One-shot completion: done_o rises in the same cycle the last beat is valid. It stays high until the next accepted start_i.
- stop_i while busy: valid_o=0 and dat_o=0 from the next cycle onward; in-flight beats are discarded; done_o not set; busy_o=0 next cycle.
- start_i while busy: ignored. start_i & stop_i together in IDLE: no effect.
- length_i=0: single beat, done_o with that beat.
- Max length (all ones): 2^(AW-1) beats; counter wraps cleanly.
- busy_o is registered and equals (state != IDLE).

Decomposition:
- Shared package ritc_pkg:
  - RITC_SAMPLE_W=3
  - RITC_BEAT_W=48
  - RITC_HALF_W=24
  - playback state enum {IDLE, ARMED, PLAY}
- Sub-module ritc_pattern_bank: simple dual-port RAM, 24 bits × 2^(AW-1), synchronous write, registered read, 1-cycle latency. Instantiated twice (lo, hi).

Test Plan:
- Reset mid-PLAY (rst_n_i low one cycle) → dat_o=0, valid_o=0, busy_o=0, done_o=0 immediately, before the next clock edge; subsequent user read of addr 5 returns pre-reset contents.
- Load words addr0=0x000001, addr1=0x000002, addr2=0x000003, addr3=0x000004; length_i=1, loop_i=0; start with sync_i=1 for 2 cycles then 0 → dat_o=0x000002000001 at T+2 and 0x000004000003 at T+3, valid_o exactly 2 cycles, done_o high from T+3.
- Same pattern with loop_i=1 for 10 cycles → dat_o alternates beat0/beat1 with no gap; stop_i → valid_o=0 next cycle, done_o stays 0.
- Write addr3=0xFFFFFF while busy → user read of addr3 returns 0x00000004; write after IDLE → read returns 0x00FFFFFF one cycle after the rd strobe.
- length_i=0 → single valid beat, done_o set in that cycle; start_i during PLAY ignored (no restart, beat order unchanged).
- length_i=511 (AW=10), one-shot → exactly 512 consecutive valid beats, beat 511 from addr 1022/1023, then IDLE.
